// File: rtl/instruction_fetch_stage_pkg.sv
// instruction_fetch_stage_pkg: shared fetch constants and FSM state type
package instruction_fetch_stage_pkg;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] CPU_NOP_INSTR = 32'h0000_0013;
    typedef enum logic {S_REQ, S_HOLD} if_state_t;
endpackage

// File: rtl/instruction_fetch_stage_pc_unit.sv
// pc_unit: PC register with +4 incrementer and word-aligned redirect mux
module pc_unit
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_advance,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_next
);
    logic [PC_W-1:0] r_pc;
    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= RESET_PC;
        else if (i_redirect)
            r_pc <= i_target & ~PC_W'(3);
        else if (i_advance)
            r_pc <= o_pc_next;
    end
    assign o_pc      = r_pc;
    assign o_pc_next = r_pc + PC_W'(4);
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: IF stage FSM fetching from imem with stall hold buffer and branch redirect
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [PC_W-1:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] imem_readdata,
    input  logic            imem_busywait,
    output logic            imem_read,
    output logic [PC_W-1:0] imem_address,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_next_out,
    output logic [PC_W-1:0] instruction,
    output logic            if_busywait
);
    if_state_t       r_state;
    if_state_t       w_state_next;
    logic [PC_W-1:0] r_buf;
    logic            w_advance;
    logic            w_capture;
    assign w_advance = (r_state == S_REQ) ? (!imem_busywait && !stall) : !stall;
    assign w_capture = (r_state == S_REQ) && !imem_busywait && stall && !branch_taken;
    pc_unit #(.RESET_PC(RESET_PC)) u_pc (
        .clk        (clk),
        .reset      (reset),
        .i_advance  (w_advance),
        .i_redirect (branch_taken),
        .i_target   (branch_target),
        .o_pc       (pc_out),
        .o_pc_next  (pc_next_out)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
            r_buf   <= NOP_INSTR;
        end else begin
            r_state <= w_state_next;
            if (w_capture)
                r_buf <= imem_readdata;
        end
    end
    always_comb begin
        w_state_next = branch_taken ? S_REQ :
                       (r_state == S_REQ) ? ((!imem_busywait && stall) ? S_HOLD : S_REQ) :
                       (stall ? S_HOLD : S_REQ);
    end
    // Memory data reaches the output only for a live, completed read
    always_comb begin
        imem_read    = (r_state == S_REQ);
        imem_address = pc_out;
        if_busywait  = (r_state == S_REQ) && imem_busywait;
        instruction  = branch_taken ? NOP_INSTR :
                       (r_state == S_REQ) ? (imem_busywait ? NOP_INSTR : imem_readdata) :
                       r_buf;
    end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed plus randomized checks against a behavioural fetch model
module tb_instruction_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RST = 32'h0000_0000;
    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, imem_busywait;
    logic [31:0] branch_target, imem_readdata;
    logic        imem_read, if_busywait;
    logic [31:0] imem_address, pc_out, pc_next_out, instruction;
    logic        ovr_en;
    logic [31:0] ovr, mem_xor;
    logic [31:0] m_pc, m_buf;
    logic        m_hold;
    int          total = 0;
    int          bad = 0;
    instruction_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_readdata (imem_readdata),
        .imem_busywait (imem_busywait),
        .imem_read     (imem_read),
        .imem_address  (imem_address),
        .pc_out        (pc_out),
        .pc_next_out   (pc_next_out),
        .instruction   (instruction),
        .if_busywait   (if_busywait)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] mem(input logic [31:0] a);
        return ovr_en ? ovr : (a ^ mem_xor);
    endfunction
    assign imem_readdata = mem(imem_address);
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask
    task automatic cyc(input logic st, input logic bz, input logic br, input logic [31:0] tg);
        logic [31:0] d;
        stall = st;
        imem_busywait = bz;
        branch_taken = br;
        branch_target = tg;
        @(negedge clk);
        d = mem(m_pc);
        chk("pc_out", pc_out, m_pc);
        chk("pc_next_out", pc_next_out, m_pc + 32'd4);
        chk("imem_address", imem_address, m_pc);
        chk("imem_read", 32'(imem_read), 32'(!m_hold));
        chk("if_busywait", 32'(if_busywait), 32'(!m_hold && bz));
        chk("instruction", instruction, br ? NOP : (m_hold ? m_buf : (bz ? NOP : d)));
        if (br) begin
            m_pc = tg & ~32'd3;
            m_hold = 1'b0;
        end else if (!m_hold) begin
            if (!bz && st) begin
                m_buf = d;
                m_hold = 1'b1;
            end else if (!bz)
                m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_pc = m_pc + 32'd4;
            m_hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic rst(input logic st, input logic br);
        reset = 1'b1;
        stall = st;
        branch_taken = br;
        branch_target = 32'h7777_7770;
        imem_busywait = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc = RST;
        m_hold = 1'b0;
        m_buf = NOP;
    endtask
    initial begin
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        imem_busywait = 1'b0;
        ovr_en = 1'b0;
        ovr = '0;
        mem_xor = '0;
        rst(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, '0);
        chk("free_run_pc", pc_out, 32'h10);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("after_busy_pc", pc_out, 32'h14);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0);
        ovr_en = 1'b1;
        ovr = 32'hDEAD_BEEF;
        cyc(1'b1, 1'b0, 1'b0, '0);
        ovr_en = 1'b0;
        chk("hold_pc", pc_out, 32'h20);
        chk("hold_instr", instruction, 32'hDEAD_BEEF);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("after_hold_pc", pc_out, 32'h24);
        cyc(1'b0, 1'b0, 1'b1, 32'h40);
        cyc(1'b0, 1'b1, 1'b1, 32'h103);
        chk("redirect_pc", pc_out, 32'h100);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_next", pc_next_out, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("wrap_pc", pc_out, 32'h0);
        ovr_en = 1'b1;
        ovr = 32'hCAFE_F00D;
        cyc(1'b1, 1'b0, 1'b0, '0);
        ovr_en = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, '0);
        rst(1'b1, 1'b1);
        chk("reset_pc", pc_out, RST);
        chk("reset_read", 32'(imem_read), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        mem_xor = 32'h1234_5678;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0)
                rst(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 15) == 0), $urandom);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
